// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and address constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} fetch_state_t;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR = 32'h0;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: Avalon single-word read bus between fetch and memory
interface instruction_fetch_if;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master (output address, read, input waitrequest, readdata);
  modport slave (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC ownership, Avalon instruction reads, delay-slot redirection and halt at address 0
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instruction_fetch_if.master        bus,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic [31:0]                pc_out,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_target,
  output logic                       active
);
  fetch_state_t state, state_d;
  logic [31:0] pc, pc_d, pending_target, target_d, instr_d, pc_out_d, next_pc;
  logic pending, pending_d, take;
  assign bus.address = pc;
  assign bus.read = state == FETCH;
  assign instr_valid = state == HOLD;
  assign active = state != HALTED;
  // A delay slot's own redirect is ignored; the earlier branch's target wins.
  assign take = !pending && redirect;
  assign next_pc = pending ? pending_target : pc_out + 32'd4;
  always_comb begin
    state_d = state;
    pc_d = pc;
    pending_d = pending;
    target_d = pending_target;
    instr_d = instr;
    pc_out_d = pc_out;
    case (state)
      IDLE: begin
        state_d = FETCH;
        pc_d = RESET_VECTOR;
      end
      FETCH: if (!bus.waitrequest) begin
        instr_d = bus.readdata;
        pc_out_d = pc;
        state_d = HOLD;
      end
      HOLD: if (!stall) begin
        pending_d = take;
        target_d = take ? {redirect_target[31:2], 2'b00} : pending_target;
        state_d = next_pc == HALT_ADDR ? HALTED : FETCH;
        pc_d = next_pc == HALT_ADDR ? pc : next_pc;
      end
      default: state_d = HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_VECTOR;
      pending <= 1'b0;
      pending_target <= '0;
      instr <= '0;
      pc_out <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      pending <= pending_d;
      pending_target <= target_d;
      instr <= instr_d;
      pc_out <= pc_out_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for the fetch stage
module tb_instruction_fetch;
  logic clk = 0;
  logic reset_n = 0;
  logic stall = 0;
  logic redirect = 0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr, pc_out;
  logic instr_valid, active;
  int tests = 0;
  int fails = 0;
  instruction_fetch_if bus ();
  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .stall(stall), .redirect(redirect), .redirect_target(redirect_target), .active(active)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_fetch(input string tag, input logic [31:0] a);
    chk({tag, " read"}, {31'd0, bus.read}, 32'd1);
    chk({tag, " address"}, bus.address, a);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
  endtask
  task automatic chk_hold(input string tag, input logic [31:0] d, input logic [31:0] p);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " read"}, {31'd0, bus.read}, 32'd0);
    chk({tag, " instr"}, instr, d);
    chk({tag, " pc_out"}, pc_out, p);
  endtask
  task automatic chk_halt(input string tag);
    chk({tag, " active"}, {31'd0, active}, 32'd0);
    chk({tag, " read"}, {31'd0, bus.read}, 32'd0);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
  endtask
  initial begin
    bus.waitrequest = 0;
    bus.readdata = 32'h24020005;
    tick();
    tick();
    chk("rst read", {31'd0, bus.read}, 32'd0);
    chk("rst address", bus.address, 32'hBFC00000);
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst pc_out", pc_out, 32'd0);
    chk("rst active", {31'd0, active}, 32'd1);
    reset_n = 1;
    tick();
    chk_fetch("first", 32'hBFC00000);
    tick();
    chk_hold("first", 32'h24020005, 32'hBFC00000);
    stall = 1;
    bus.readdata = 32'hDEADBEEF;
    tick();
    chk_hold("stall1", 32'h24020005, 32'hBFC00000);
    tick();
    chk_hold("stall2", 32'h24020005, 32'hBFC00000);
    stall = 0;
    tick();
    chk_fetch("after stall", 32'hBFC00004);
    bus.waitrequest = 1;
    bus.readdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fetch("wait", 32'hBFC00004);
      chk("wait instr", instr, 32'h24020005);
    end
    bus.waitrequest = 0;
    bus.readdata = 32'h22222222;
    tick();
    chk_hold("after wait", 32'h22222222, 32'hBFC00004);
    for (logic [31:0] a = 32'hBFC00008; a <= 32'hBFC00010; a += 4) begin
      tick();
      chk_fetch("seq", a);
      bus.readdata = a ^ 32'h5A5A5A5A;
      tick();
      chk_hold("seq", a ^ 32'h5A5A5A5A, a);
    end
    redirect = 1;
    redirect_target = 32'hBFC00103;
    tick();
    chk_fetch("delay slot", 32'hBFC00014);
    redirect = 0;
    bus.readdata = 32'h00000000;
    tick();
    chk_hold("delay slot", 32'h00000000, 32'hBFC00014);
    redirect = 1;
    redirect_target = 32'h0;
    tick();
    chk_fetch("target", 32'hBFC00100);
    redirect = 0;
    bus.readdata = 32'h03E00008;
    tick();
    chk_hold("jr", 32'h03E00008, 32'hBFC00100);
    redirect = 1;
    redirect_target = 32'h0;
    tick();
    chk_fetch("jr slot", 32'hBFC00104);
    redirect = 0;
    tick();
    chk_hold("jr slot", 32'h03E00008, 32'hBFC00104);
    tick();
    chk_halt("halt");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_halt("halt stays");
    end
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rst2 active", {31'd0, active}, 32'd1);
    tick();
    chk_fetch("rst2", 32'hBFC00000);
    bus.readdata = 32'h10000003;
    tick();
    redirect = 1;
    redirect_target = 32'h00000040;
    tick();
    redirect = 0;
    chk_fetch("pend slot", 32'hBFC00004);
    bus.waitrequest = 1;
    bus.readdata = 32'hCAFEF00D;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("midrst read", {31'd0, bus.read}, 32'd0);
    chk("midrst valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst address", bus.address, 32'hBFC00000);
    chk("midrst instr", instr, 32'd0);
    tick();
    chk_fetch("midrst refetch", 32'hBFC00000);
    bus.waitrequest = 0;
    bus.readdata = 32'h24020005;
    tick();
    chk_hold("midrst", 32'h24020005, 32'hBFC00000);
    tick();
    chk_fetch("pending cleared", 32'hBFC00004);
    tick();
    redirect = 1;
    redirect_target = 32'hFFFFFFFF;
    tick();
    redirect = 0;
    chk_fetch("wrap slot", 32'hBFC00008);
    tick();
    tick();
    chk_fetch("wrap top", 32'hFFFFFFFC);
    tick();
    chk_hold("wrap top", 32'h24020005, 32'hFFFFFFFC);
    tick();
    chk_halt("wrap halt");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
